// File: rtl/ibwt_top_if.sv
// Byte-stream bus of the inverse BWT engine: BWT characters in, recovered string out.
interface ibwt_top_if;
  logic       start;
  logic [7:0] input_string_char;
  logic [7:0] output_string_char;
  logic       valid_out;
  logic       busy;
  logic       err;

  // Producer of BWT characters / consumer of the recovered string
  modport master (
    output start,
    output input_string_char,
    input  output_string_char,
    input  valid_out,
    input  busy,
    input  err
  );

  // The decoding engine
  modport slave (
    input  start,
    input  input_string_char,
    output output_string_char,
    output valid_out,
    output busy,
    output err
  );
endinterface

// File: rtl/ibwt_top.sv
// Inverse Burrows-Wheeler transform engine. Collects one BWT block of
// STRING_LEN characters, builds the symbol-count prefix table, walks the
// LF-mapping backwards to rebuild the original string, then streams it out.
module ibwt_top #(
  parameter int         STRING_LEN = 32,
  parameter logic [7:0] SENTINEL   = 8'h24
) (
  input  logic      clk,
  input  logic      rst,
  ibwt_top_if.slave bus
);
  localparam int             AW         = $clog2(STRING_LEN);
  localparam logic [7:0]     LAST_IDX   = 8'(STRING_LEN - 1);
  localparam logic [AW-1:0]  LAST_A     = AW'(STRING_LEN - 1);
  localparam logic [7:0]     WALK_FIRST = 8'(STRING_LEN - 2);

  typedef enum logic [2:0] {IDLE, LOAD, PREFIX, WALK, EMIT} state_t;
  state_t state_reg, state_next;

  // Block storage. These are read asynchronously because each LF step
  // (L -> C -> next row) has to close within a single cycle.
  logic [7:0] l_mem    [STRING_LEN];
  logic [7:0] rank_mem [STRING_LEN];
  logic [7:0] s_mem    [STRING_LEN];
  logic [7:0] cnt_mem  [256];
  logic [7:0] c_mem    [256];

  logic [7:0]    ctr_reg;
  logic [7:0]    sym_reg;
  logic [7:0]    acc_reg;
  logic [AW-1:0] r_reg;
  logic [7:0]    k_reg;
  logic [7:0]    ctr_send_reg;
  logic          low_seen_reg;
  logic          err_reg;
  logic          valid_reg;
  logic [7:0]    out_char_reg;

  logic [7:0]    in_char;
  logic          accept_first;
  logic          accept_load;
  logic          last_load;
  logic [7:0]    sent_final;
  logic          low_final;
  logic          format_ok;
  logic          prefix_done;
  logic [7:0]    walk_sym;
  logic [AW-1:0] r_next;

  assign in_char      = bus.input_string_char;
  assign accept_first = (state_reg == IDLE) && bus.start;
  assign accept_load  = (state_reg == LOAD) && bus.start;
  assign last_load    = accept_load && (ctr_reg == LAST_IDX);

  // Format check sees the count including the character being written now.
  assign sent_final = cnt_mem[SENTINEL] + {7'd0, in_char == SENTINEL};
  assign low_final  = low_seen_reg || (in_char < SENTINEL);
  assign format_ok  = (sent_final == 8'd1) && !low_final;

  assign prefix_done = (state_reg == PREFIX) && (sym_reg == 8'hFF);

  // One LF-mapping step: character of the current row, then its predecessor row.
  assign walk_sym = l_mem[r_reg];
  assign r_next   = AW'(c_mem[walk_sym] + rank_mem[r_reg]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    if (last_load) state_next = format_ok ? PREFIX : IDLE;
      PREFIX:  if (sym_reg == 8'hFF) state_next = WALK;
      WALK:    if (k_reg == 8'd0) state_next = EMIT;
      EMIT:    if (ctr_send_reg == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counters, error flag and registered output stream
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_reg      <= 8'd0;
      sym_reg      <= 8'd0;
      acc_reg      <= 8'd0;
      r_reg        <= '0;
      k_reg        <= 8'd0;
      ctr_send_reg <= 8'd0;
      low_seen_reg <= 1'b0;
      err_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      out_char_reg <= 8'd0;
    end else begin
      valid_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            ctr_reg      <= 8'd1;
            low_seen_reg <= (in_char < SENTINEL);
            err_reg      <= 1'b0;
            sym_reg      <= 8'd0;
            acc_reg      <= 8'd0;
          end
        end
        LOAD: begin
          if (bus.start) begin
            ctr_reg      <= ctr_reg + 8'd1;
            low_seen_reg <= low_final;
            if (last_load && !format_ok) err_reg <= 1'b1;
          end
        end
        PREFIX: begin
          sym_reg <= sym_reg + 8'd1;
          acc_reg <= acc_reg + cnt_mem[sym_reg];
          if (sym_reg == 8'hFF) begin
            r_reg <= '0;
            k_reg <= WALK_FIRST;
          end
        end
        WALK: begin
          r_reg <= r_next;
          k_reg <= k_reg - 8'd1;
          if (k_reg == 8'd0) ctr_send_reg <= 8'd0;
        end
        EMIT: begin
          out_char_reg <= s_mem[ctr_send_reg[AW-1:0]];
          valid_reg    <= 1'b1;
          ctr_send_reg <= ctr_send_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Symbol histogram: restarted by character 0, bumped by every later character
  always_ff @(posedge clk) begin
    for (int i = 0; i < 256; i++) begin
      if (accept_first)
        cnt_mem[i] <= (in_char == 8'(i)) ? 8'd1 : 8'd0;
      else if (accept_load && (in_char == 8'(i)))
        cnt_mem[i] <= cnt_mem[i] + 8'd1;
    end
  end

  // Block capture, prefix-sum table and reconstruction buffer writes
  always_ff @(posedge clk) begin
    if (accept_first) begin
      l_mem[0]    <= in_char;
      rank_mem[0] <= 8'd0;
    end
    if (accept_load) begin
      l_mem[ctr_reg[AW-1:0]]    <= in_char;
      rank_mem[ctr_reg[AW-1:0]] <= cnt_mem[in_char];
    end
    if (state_reg == PREFIX) c_mem[sym_reg] <= acc_reg;
    if (prefix_done)
      s_mem[LAST_A] <= SENTINEL;
    else if (state_reg == WALK)
      s_mem[k_reg[AW-1:0]] <= walk_sym;
  end

  assign bus.output_string_char = out_char_reg;
  assign bus.valid_out          = valid_reg;
  assign bus.busy               = (state_reg != IDLE);
  assign bus.err                = err_reg;
endmodule

// File: tb/tb_ibwt_top.sv
// Self-checking bench for ibwt_top: directed blocks plus a randomized
// loopback where the bench computes the forward BWT itself by sorting rotations.
module tb_ibwt_top;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ibwt_top_if bus7();
  ibwt_top_if bus2();
  ibwt_top_if bus32();

  ibwt_top #(.STRING_LEN(7),  .SENTINEL(8'h24)) u7  (.clk(clk), .rst(rst), .bus(bus7.slave));
  ibwt_top #(.STRING_LEN(2),  .SENTINEL(8'h24)) u2  (.clk(clk), .rst(rst), .bus(bus2.slave));
  ibwt_top #(.STRING_LEN(32), .SENTINEL(8'h24)) u32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  src   [256];
  logic [7:0]  stim  [256];
  logic [7:0]  exp_s [256];
  logic [7:0]  got   [256];
  logic [31:0] o_valid, o_char, o_busy, o_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drv(input int sel, input logic s, input logic [7:0] c);
    case (sel)
      7:       begin bus7.start  = s; bus7.input_string_char  = c; end
      2:       begin bus2.start  = s; bus2.input_string_char  = c; end
      default: begin bus32.start = s; bus32.input_string_char = c; end
    endcase
  endtask

  task automatic snap(input int sel);
    case (sel)
      7: begin
        o_valid = {31'd0, bus7.valid_out}; o_char = {24'd0, bus7.output_string_char};
        o_busy  = {31'd0, bus7.busy};      o_err  = {31'd0, bus7.err};
      end
      2: begin
        o_valid = {31'd0, bus2.valid_out}; o_char = {24'd0, bus2.output_string_char};
        o_busy  = {31'd0, bus2.busy};      o_err  = {31'd0, bus2.err};
      end
      default: begin
        o_valid = {31'd0, bus32.valid_out}; o_char = {24'd0, bus32.output_string_char};
        o_busy  = {31'd0, bus32.busy};      o_err  = {31'd0, bus32.err};
      end
    endcase
  endtask

  task automatic load_stim(input string s);
    for (int i = 0; i < s.len(); i++) stim[8'(i)] = s[i];
  endtask

  task automatic load_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_s[8'(i)] = s[i];
  endtask

  // Reference: rotation a sorts before rotation b of src[0..n-1]
  function automatic bit rot_less(input int n, input int a, input int b);
    for (int k = 0; k < n; k++) begin
      logic [7:0] ca, cb;
      ca = src[8'((a + k) % n)];
      cb = src[8'((b + k) % n)];
      if (ca != cb) return (ca < cb);
    end
    return 1'b0;
  endfunction

  // Reference forward BWT: last column of the sorted rotation matrix
  function automatic void make_bwt(input int n);
    int idx [256];
    int t;
    for (int i = 0; i < n; i++) idx[i] = i;
    for (int i = 1; i < n; i++) begin
      int j;
      j = i;
      while (j > 0 && rot_less(n, idx[j], idx[j-1])) begin
        t = idx[j]; idx[j] = idx[j-1]; idx[j-1] = t;
        j--;
      end
    end
    for (int i = 0; i < n; i++) stim[8'(i)] = src[8'((idx[i] + n - 1) % n)];
  endfunction

  // Stream stim[0..n-1]; returns at the first sample point after the last capture edge
  task automatic feed(input int sel, input int n, input int max_gap, input string tag);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat ($urandom_range(0, max_gap)) begin
          drv(sel, 1'b0, 8'h00);
          @(negedge clk);
        end
      end
      drv(sel, 1'b1, stim[8'(i)]);
      @(negedge clk);
      if (i == 0) begin
        snap(sel);
        chk({tag, " busy_after_char0"}, o_busy, 32'd1);
        chk({tag, " err_cleared"}, o_err, 32'd0);
      end
    end
    drv(sel, 1'b0, 8'h00);
  endtask

  task automatic run_block(input int sel, input int n, input int max_gap,
                           input bit expect_err, input string tag);
    int lat, nout, j, lastj, nv;
    feed(sel, n, max_gap, tag);
    snap(sel);
    if (expect_err) begin
      chk({tag, " err_at_e0"}, o_err, 32'd1);
      chk({tag, " busy_at_e0"}, o_busy, 32'd0);
      nv = 0;
      repeat (300) begin
        @(negedge clk);
        snap(sel);
        if (o_valid == 32'd1) nv++;
      end
      chk({tag, " no_valid_on_error"}, 32'(nv), 32'd0);
      $display("block %s n=%0d err=%0d valid_pulses=%0d", tag, n, o_err, nv);
    end else begin
      chk({tag, " err_low"}, o_err, 32'd0);
      lat = -1; nout = 0; j = 1; lastj = 0;
      while (o_busy == 32'd1 && j < 2 * n + 400) begin
        @(negedge clk);
        j++;
        snap(sel);
        if (o_valid == 32'd1) begin
          if (lat < 0) lat = j - 1;
          if (nout < 256) got[8'(nout)] = o_char[7:0];
          nout++;
          lastj = j;
        end
      end
      chk({tag, " finished"}, o_busy, 32'd0);
      chk({tag, " latency"}, 32'(lat), 32'(n + 256));
      chk({tag, " count"}, 32'(nout), 32'(n));
      chk({tag, " consecutive"}, 32'(lastj - lat), 32'(n));
      for (int i = 0; i < n; i++)
        chk({tag, $sformatf(" char%0d", i)}, {24'd0, got[8'(i)]}, {24'd0, exp_s[8'(i)]});
      $display("block %s n=%0d latency=%0d outputs=%0d", tag, n, lat, nout);
    end
  endtask

  initial begin
    int nv;
    rst = 1'b1;
    drv(7, 1'b0, 8'h00);
    drv(2, 1'b0, 8'h00);
    drv(32, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    snap(7);
    chk("reset valid", o_valid, 32'd0);
    chk("reset char", o_char, 32'd0);
    chk("reset busy", o_busy, 32'd0);
    chk("reset err", o_err, 32'd0);
    snap(32);
    chk("reset busy32", o_busy, 32'd0);
    @(negedge clk);

    // Back-to-back, then gapped, decode of the canonical example
    load_stim("annb$aa"); load_exp("banana$");
    run_block(7, 7, 0, 1'b0, "n7_b2b");
    run_block(7, 7, 3, 1'b0, "n7_gaps");

    // Minimum block length, then output holds while valid is low
    load_stim("a$"); load_exp("a$");
    run_block(2, 2, 0, 1'b0, "n2");
    @(negedge clk);
    snap(2);
    chk("n2 valid_low_after", o_valid, 32'd0);
    chk("n2 char_holds", o_char, 32'h24);

    // Two sentinels: error path, then recovery
    load_stim("an$b$aa");
    run_block(7, 7, 0, 1'b1, "n7_two_sent");
    load_stim("annb$aa"); load_exp("banana$");
    run_block(7, 7, 0, 1'b0, "n7_recover");

    // Reset during WALK aborts the block
    load_stim("annb$aa");
    feed(7, 7, 0, "n7_rst");
    repeat (257) @(negedge clk);
    snap(7);
    chk("n7_rst busy_in_walk", o_busy, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    snap(7);
    chk("n7_rst busy_after", o_busy, 32'd0);
    chk("n7_rst valid_after", o_valid, 32'd0);
    chk("n7_rst char_after", o_char, 32'd0);
    nv = 0;
    repeat (300) begin
      @(negedge clk);
      snap(7);
      if (o_valid == 32'd1) nv++;
    end
    chk("n7_rst no_valid", 32'(nv), 32'd0);
    $display("block n7_rst aborted valid_pulses=%0d", nv);
    load_exp("banana$");
    run_block(7, 7, 0, 1'b0, "n7_after_rst");

    // Randomized loopback on 32-character blocks
    for (int b = 0; b < 100; b++) begin
      for (int i = 0; i < 31; i++) src[8'(i)] = 8'($urandom_range(8'h25, 8'hff));
      src[31] = 8'h24;
      make_bwt(32);
      for (int i = 0; i < 32; i++) exp_s[8'(i)] = src[8'(i)];
      run_block(32, 32, 0, 1'b0, $sformatf("n32_loop%0d", b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
